// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin grant arbiter.
//   N_REQ       : number of requesters
//   ID_W        : width of an owner index
//   arb_state_t : arbiter FSM state (IDLE / GRANT)
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational 3-to-8 one-hot decoder.
//   idx    : input  [2:0]  index to decode
//   onehot : output [7:0]  bit idx set, all others clear
module onehot_dec3to8
  import rr_arb_pkg::*;
(
  input  logic [ID_W-1:0]  idx,
  output logic [N_REQ-1:0] onehot
);

  assign onehot = N_REQ'(1) << idx;

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter sharing one resource between 8 requesters. A grant is
// held until the owner signals done or withdraws its request; at least one
// IDLE cycle separates consecutive grants. After a release the search for the
// next winner starts at the index just past the previous owner.
//
// Optional feature (macro ARB_TIMEOUT_EN): a hold counter force-releases a
// grant after TIMEOUT_CYCLES cycles and pulses timeout for one cycle.
// Without the macro, timeout is tied to 0 and grants are held indefinitely.
//
// Ports:
//   clk       : input        system clock, rising edge
//   rst       : input        asynchronous active-high reset
//   req       : input  [7:0] level-sensitive request vector
//   done      : input        current owner finished (sampled only in GRANT)
//   gnt       : output [7:0] registered one-hot grant, zero when idle
//   gnt_id    : output [2:0] registered owner index (holds last value)
//   gnt_valid : output       registered grant-active flag
//   timeout   : output       one-cycle pulse on forced release
module rr_grant_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_grant_arbiter8: TIMEOUT_CYCLES must be in 2..255");
  end

  // First requester found scanning p, p+1, ..., p+7 (mod 8). Only meaningful
  // when at least one request bit is set.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] idx;
    logic            found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = p + ID_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_id;
  logic [N_REQ-1:0] win_onehot;
  logic             take;
  logic             rel;

  assign win_id = rr_pick(req, ptr);

  onehot_dec3to8 u_dec (
    .idx    (win_id),
    .onehot (win_onehot)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] hold_cnt;
  logic       tmo_fire;
`endif

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    rel       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          take      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // A normal release (done or withdrawal) takes precedence over expiry,
        // so a coincident done never produces a timeout pulse.
        if (done || !req[gnt_id]) begin
          rel       = 1'b1;
          state_nxt = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          rel       = 1'b1;
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        gnt_id    <= win_id;
        gnt       <= win_onehot;
        gnt_valid <= 1'b1;
      end
      if (rel) begin
        gnt       <= '0;
        gnt_valid <= 1'b0;
        ptr       <= gnt_id + ID_W'(1);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      if (take) begin
        hold_cnt <= 8'd0;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
      timeout <= tmo_fire;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
module tb_rr_grant_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] id;
    logic       v;
    logic       t;
  } snap_t;

  snap_t q[$];
  string tq[$];
  int    checks   = 0;
  int    failures = 0;

  rr_grant_arbiter8 #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected snapshot is consumed per falling edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      snap_t e;
      string n;
      e = q.pop_front();
      n = tq.pop_front();
      checks++;
      if (gnt !== e.g || gnt_id !== e.id || gnt_valid !== e.v || timeout !== e.t) begin
        failures++;
        $display("FAIL %s: got gnt=%h id=%0d vld=%b tmo=%b, want gnt=%h id=%0d vld=%b tmo=%b",
                 n, gnt, gnt_id, gnt_valid, timeout, e.g, e.id, e.v, e.t);
      end
    end
  end

  task automatic expect_out(input string n, input logic [7:0] g, input logic [2:0] id,
                            input logic v, input logic t);
    snap_t s;
    s.g = g; s.id = id; s.v = v; s.t = t;
    q.push_back(s);
    tq.push_back(n);
  endtask

  // Drive inputs in the low phase, expect outputs after the next rising edge.
  task automatic cyc(input string n, input logic [7:0] r, input logic d,
                     input logic [7:0] g, input logic [2:0] id, input logic v,
                     input logic t);
    req  = r;
    done = d;
    @(posedge clk);
    expect_out(n, g, id, v, t);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    expect_out("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-grant
    cyc("grant2", 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    cyc("hold2", 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    req = 8'hFF;
    expect_out("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_reset_grant0", 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    cyc("release0", 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Rotation 1..7 then 0, one IDLE cycle between grants
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] id;
      logic [7:0] g;
      id = 3'(k % 8);
      g  = 8'h01 << id;
      cyc($sformatf("rot_grant%0d", id), 8'hFF, 1'b0, g, id, 1'b1, 1'b0);
      cyc($sformatf("rot_rel%0d", id), 8'hFF, 1'b1, 8'h00, id, 1'b0, 1'b0);
    end

    // Single requester 5, ptr becomes 6
    cyc("single5", 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    cyc("single5_rel", 8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);

    // Wrap-around and skip: grant 6 sets ptr=7, then 0x41 alternates 0,6
    cyc("grant6", 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
    cyc("rel6", 8'h40, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0);
    cyc("wrap_grant0", 8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    cyc("wrap_rel0", 8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    cyc("skip_grant6", 8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
    cyc("skip_rel6", 8'h41, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0);
    cyc("wrap_grant0b", 8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    cyc("wrap_rel0b", 8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Owner withdrawal, then done in IDLE
    cyc("grant3", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    cyc("hold3", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    cyc("withdraw3", 8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
    cyc("done_idle_a", 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    cyc("done_idle_b", 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    cyc("done_idle_grant0", 8'h09, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    cyc("rel0_c", 8'h09, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    cyc("grant3b", 8'h09, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    cyc("rel3b", 8'h09, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);

    // Timeout (ptr=4, req=0x03 -> owner 0)
    cyc("tmo_grant0", 8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      cyc($sformatf("tmo_hold0_%0d", i), 8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    cyc("tmo_expire0", 8'h03, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    cyc("tmo_grant1", 8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("tmo_hold1_%0d", i), 8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
    cyc("done_at_expiry", 8'h03, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0);
`else
    for (int i = 0; i < 8; i++)
      cyc($sformatf("no_tmo_hold0_%0d", i), 8'h03, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    cyc("no_tmo_rel0", 8'h03, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
`endif

    req  = 8'h00;
    done = 1'b0;
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected snapshots left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Each grant is held until the owner signals completion, then the grant moves on.
- The grant is output two ways:
  - as a 3-bit owner index;
  - as a one-hot 8-bit vector, produced by a 3-to-8 one-hot decode of the index.
- Placed in front of any shared unit selected by a one-hot enable: bus, memory port, display digit.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles one grant may be held. Used only with ARB_TIMEOUT_EN. Legal range is 2..255.

Ports:
- clk  input  1  System clock. All state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- req  input  8  Request vector. Bit i is requester i. Level-sensitive.
- done  input  1  Current owner has finished. Sampled only in GRANT.
- gnt  output  8  One-hot grant vector, registered. All zeros when nothing is granted.
- gnt_id  output  3  Index of the current owner, registered. Meaningful only while gnt_valid=1.
- gnt_valid  output  1  A grant is active, registered.
- timeout  output  1  One-cycle pulse when a grant is force-released. Constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=3'd0. State=IDLE. Hold counter=0.
- State machine: 2 states, IDLE and GRANT. State register is a 1-bit enumeration.
- IDLE:
  - If req==0: stay in IDLE; outputs stay at their reset values.
  - Else pick the winner w: the first index with req[w]=1, searching ptr, ptr+1, ..., ptr+7 modulo 8.
  - On that edge: gnt_id<=w, gnt<=1<<w, gnt_valid<=1, counter<=0, state<=GRANT.
  - Latency: req sampled at edge k gives gnt visible after edge k (one cycle from request to grant).
- GRANT:
  - The grant is held constant.
  - Release condition (any of):
    - done=1;
    - req[gnt_id]=0 (owner withdrew);
    - timeout expiry, only with ARB_TIMEOUT_EN.
  - On release: gnt<=0, gnt_valid<=0, ptr<=gnt_id+1 (7 wraps to 0), state<=IDLE.
  - gnt_id keeps its last value.
  - There is always at least one IDLE cycle between two grants. No back-to-back handover.
- Requests from non-owners during GRANT are ignored. They are not queued; req is level-sensitive.
- done while in IDLE is ignored.
- When release happens and other requests are pending, the next arbitration in IDLE uses the updated ptr.
- Fairness: a requester that holds req high is granted within at most 7 other grants.
- Invariants:
  - gnt is always zero or exactly one-hot.
  - gnt==(1<<gnt_id) whenever gnt_valid=1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter increments each GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no other release condition, the grant is force-released (same release actions as above).
  - timeout=1 for the cycle after that edge (registered pulse).
  - If done and expiry coincide, this counts as a normal release: timeout stays 0.
- Undefined:
  - No counter logic.
  - timeout tied to 0.
  - A grant persists until done or owner withdrawal.

Decomposition:
- Shared package rr_arb_pkg:
  - state enum: IDLE=1'b0, GRANT=1'b1;
  - N_REQ=8, ID_W=3.
- Sub-module onehot_dec3to8:
  - purely combinational 3-bit index to 8-bit one-hot;
  - instantiated once to build the next gnt value from the winner index.
- Top level holds the FSM, pointer, rotating priority search and counter.

Test Plan:
- Reset mid-grant: grant req=8'h04; assert rst asynchronously between clock edges -> gnt=0, gnt_valid=0 immediately. After reset, first grant with req=8'hFF goes to index 0.
- Single requester: req=8'h20 -> gnt=8'h20, gnt_id=5 one edge later. Pulse done -> gnt=0 next edge, ptr=6.
- Rotation: req=8'hFF held, done pulsed each GRANT cycle -> grants in order 0,1,2,...,7,0. Each is separated by one IDLE cycle.
- Wrap-around and skip: ptr=7 (after a grant to 6), req=8'h41 -> grant to 0, then to 6. Index 7 is never granted.
- Owner withdrawal and done-in-IDLE: grant to 3; drop req[3] with done=0 -> released next edge. A done pulse in IDLE has no effect.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): req=8'h03, done held 0 -> grant to 0 released after 4 GRANT cycles, timeout pulses 1 cycle, next grant goes to 1. Without the macro, the grant to 0 holds indefinitely.
